// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the clock-divider bank.
package clk_div_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_DIV   = 2;
  localparam int MIN_DIV   = 2;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

  // High-phase length ceil(d/2); 32-bit arithmetic keeps the carry of d+1.
  function automatic logic [31:0] half_hi(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor, run flag and sticky config error.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             sync,
  output logic             div_out,
  output logic             tick,
  output logic             cfg_err
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] pending;
  logic             pend_vld;
  logic             run;

  logic             load_ok;
  logic             load_bad;
  logic             new_vld;
  logic [CNT_W-1:0] new_div;
  logic [CNT_W-1:0] cnt_inc;
  logic             wrap;
  logic             hi_next;

  assign load_ok  = div_load && (div_val >= CNT_W'(MIN_DIV));
  assign load_bad = div_load && (div_val <  CNT_W'(MIN_DIV));
  // A legal load in the same cycle as an apply point wins over the older pending value.
  assign new_vld  = load_ok || pend_vld;
  assign new_div  = load_ok ? div_val : pending;
  assign cnt_inc  = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign wrap     = (cnt_inc == active);
  assign hi_next  = (32'(cnt_inc) < half_hi(32'(active)));

  // Channel state: sync beats start/wrap; pending divisors apply only at period boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      active   <= CNT_W'(DEFAULT_DIV);
      pending  <= CNT_W'(DEFAULT_DIV);
      pend_vld <= 1'b0;
      run      <= 1'b0;
      div_out  <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (load_bad) cfg_err <= 1'b1;
      if (load_ok) begin
        pending  <= div_val;
        pend_vld <= 1'b1;
      end
      if (sync && en) begin
        if (new_vld) begin
          active   <= new_div;
          pend_vld <= 1'b0;
        end
        cnt     <= '0;
        run     <= 1'b1;
        div_out <= 1'b1;
        tick    <= 1'b1;
      end else if (!run) begin
        if (new_vld) begin
          active   <= new_div;
          pend_vld <= 1'b0;
        end
        cnt     <= '0;
        run     <= en;
        div_out <= en;
        tick    <= en;
      end else if (wrap) begin
        if (new_vld) begin
          active   <= new_div;
          pend_vld <= 1'b0;
        end
        cnt     <= '0;
        run     <= en;
        div_out <= en;
        tick    <= en;
      end else begin
        cnt     <= cnt_inc;
        div_out <= hi_next;
        tick    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers sharing one clock and a global phase sync.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       div_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       cfg_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en[i]),
      .div_val  (div_val[i*CNT_W +: CNT_W]),
      .div_load (div_load[i]),
      .sync     (sync),
      .div_out  (div_out[i]),
      .tick     (tick[i]),
      .cfg_err  (cfg_err[i])
    );
  end

endmodule
